// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, controller handshake and branch redirect.
// The master modport is the fetch unit; the slave modport is the memory/controller side.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  start_pc;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    modport master (
        input  start_pc, mem_rdata, instr_ready, redirect, redirect_pc,
        output mem_addr, mem_rd, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start_pc, mem_rdata, instr_ready, redirect, redirect_pc,
        input  mem_addr, mem_rd, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous-read instruction memory and presents
// one instruction at a time over valid/ready, with branch redirect and a sticky HALT stop.
module instr_fetch_unit #(
    parameter int         ADDR_W  = 8,
    parameter int         INSTR_W = 16,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q, halted_d;
    logic               is_halt_s;

    assign is_halt_s = (instr_q[INSTR_W-1 -: 3] == HALT_OP);

    // Next-state logic; redirect outranks the ready handshake in every state that honours it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        case (state_q)
            S_LOAD: begin
                pc_d    = bus.start_pc;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = S_REQ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect here drops the word already in flight from memory.
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = S_REQ;
                end else begin
                    instr_d       = bus.mem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d          = bus.redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (is_halt_s) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d       = S_LOAD;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.mem_rd      = (state_q == S_REQ);
    assign bus.mem_addr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized stream checked
// against a transaction-level model (expected next PC and the memory image).
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [15:0] mem [0:255];

    instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .HALT_OP(3'b111)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] sp);
        rst_n = 1'b0;
        bus.redirect = 1'b0;
        bus.start_pc = 8'($urandom);
        tick();
        tick();
        bus.start_pc = sp;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd, bus.halted, bus.mem_addr} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_state: instr=%h pc=%h valid=%b rd=%b halted=%b addr=%h, want all zero",
                     bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd, bus.halted, bus.mem_addr);
        end
    endtask

    task automatic test_first_fetch_and_hold();
        mem[8'h04] = 16'hD105;
        mem[8'h05] = 16'h0505;
        bus.instr_ready = 1'b1;
        apply_reset(8'h04);
        tick();
        vectors++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid} !== {1'b1, 8'h04, 1'b0}) begin
            miscompares++;
            $display("FAIL first_req: rd=%b addr=%h valid=%b, want 1/04/0", bus.mem_rd, bus.mem_addr, bus.instr_valid);
        end
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'hD105, 8'h04, 1'b1}) begin
            miscompares++;
            $display("FAIL first_instr: instr=%h pc=%h valid=%b, want D105/04/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd} !== {16'hD105, 8'h04, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: instr=%h pc=%h valid=%b rd=%b, want D105/04/1/0",
                         i, bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd);
            end
        end
        bus.instr_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid} !== {1'b1, 8'h05, 1'b0}) begin
            miscompares++;
            $display("FAIL after_hold_req: rd=%b addr=%h valid=%b, want 1/05/0", bus.mem_rd, bus.mem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_pc_wrap();
        mem[8'hFF] = 16'h1234;
        mem[8'h00] = 16'h0F0F;
        bus.instr_ready = 1'b1;
        apply_reset(8'hFF);
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'h1234, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_ff_instr: instr=%h pc=%h valid=%b, want 1234/FF/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
        tick();
        vectors++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL wrap_addr: rd=%b addr=%h, want 1/00", bus.mem_rd, bus.mem_addr);
        end
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'h0F0F, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_00_instr: instr=%h pc=%h valid=%b, want 0F0F/00/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
    endtask

    // Ends in the request state at pc 44, which the random stream picks up from.
    task automatic test_redirect_and_random_stream();
        logic [7:0] exp_pc;
        logic [7:0] tgt;
        logic       red;
        logic       rdy;
        int         consumed;
        mem[8'h20] = 16'h2020;
        mem[8'h30] = 16'h3030;
        bus.instr_ready = 1'b0;
        apply_reset(8'h30);
        tick();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h20;
        tick();
        bus.redirect = 1'b0;
        vectors++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 8'h20}) begin
            miscompares++;
            $display("FAIL redirect_wait: valid=%b rd=%b addr=%h, want 0/1/20", bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'h2020, 8'h20, 1'b1}) begin
            miscompares++;
            $display("FAIL redirect_target_instr: instr=%h pc=%h valid=%b, want 2020/20/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h44;
        tick();
        bus.redirect = 1'b0;
        vectors++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 8'h44}) begin
            miscompares++;
            $display("FAIL redirect_hold: valid=%b rd=%b addr=%h, want 0/1/44", bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        exp_pc = 8'h44;
        consumed = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bus.mem_rd) begin
                vectors++;
                if ({bus.mem_addr, bus.instr_valid} !== {exp_pc, 1'b0}) begin
                    miscompares++;
                    $display("FAIL rand_req[%0d]: addr=%h valid=%b, want %h/0", cyc, bus.mem_addr, bus.instr_valid, exp_pc);
                end
            end
            if (bus.instr_valid) begin
                vectors++;
                if ({bus.instr, bus.instr_pc} !== {mem[exp_pc], exp_pc}) begin
                    miscompares++;
                    $display("FAIL rand_instr[%0d]: instr=%h pc=%h, want %h/%h", cyc, bus.instr, bus.instr_pc, mem[exp_pc], exp_pc);
                end
            end
            red = ($urandom_range(0, 9) == 0);
            rdy = 1'($urandom);
            tgt = 8'($urandom);
            bus.redirect = red;
            bus.redirect_pc = tgt;
            bus.instr_ready = rdy;
            if (red) begin
                exp_pc = tgt;
            end else if (bus.instr_valid && rdy) begin
                exp_pc = exp_pc + 8'd1;
                consumed++;
            end
            tick();
        end
        bus.redirect = 1'b0;
        vectors++;
        if (consumed < 20) begin
            miscompares++;
            $display("FAIL rand_progress: consumed=%0d, want at least 20", consumed);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sp;
        logic [7:0] exp_pc;
        int         last;
        int         first;
        int         seen;
        sp = 8'($urandom_range(8'h80, 8'hC0));
        bus.instr_ready = 1'b1;
        apply_reset(sp);
        exp_pc = sp;
        last = -1;
        first = -1;
        seen = 0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            tick();
            if (bus.instr_valid) begin
                vectors++;
                if ({bus.instr, bus.instr_pc} !== {mem[exp_pc], exp_pc}) begin
                    miscompares++;
                    $display("FAIL b2b_instr[%0d]: instr=%h pc=%h, want %h/%h", cyc, bus.instr, bus.instr_pc, mem[exp_pc], exp_pc);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== 3) begin
                        miscompares++;
                        $display("FAIL b2b_gap[%0d]: gap=%0d, want 3", cyc, cyc - last);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                exp_pc = exp_pc + 8'd1;
                seen++;
            end
        end
        vectors++;
        if ({first, seen} !== {32'sd2, 32'sd12}) begin
            miscompares++;
            $display("FAIL b2b_count: first_valid_edge_idx=%0d count=%0d, want 2/12", first, seen);
        end
    endtask

    task automatic test_halt();
        mem[8'h06] = 16'hE000;
        mem[8'h40] = 16'h4040;
        bus.instr_ready = 1'b0;
        apply_reset(8'h06);
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_valid} !== {16'hE000, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_present: instr=%h valid=%b, want E000/1", bus.instr, bus.instr_valid);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h40;
        bus.instr_ready = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b0;
        vectors++;
        if ({bus.halted, bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b0, 1'b1, 8'h40}) begin
            miscompares++;
            $display("FAIL redirect_beats_halt: halted=%b valid=%b rd=%b addr=%h, want 0/0/1/40",
                     bus.halted, bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        tick();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h06;
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'hE000, 8'h06, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_refetch: instr=%h pc=%h valid=%b, want E000/06/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            vectors++;
            if ({bus.halted, bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b1, 1'b0, 1'b0, 8'h06}) begin
                miscompares++;
                $display("FAIL halted[%0d]: halted=%b valid=%b rd=%b addr=%h, want 1/0/0/06",
                         i, bus.halted, bus.instr_valid, bus.mem_rd, bus.mem_addr);
            end
            bus.redirect = 1'($urandom);
            bus.redirect_pc = 8'($urandom);
        end
        bus.redirect = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        mem[8'h50] = 16'h5A5A;
        mem[8'h51] = 16'h5151;
        mem[8'h10] = 16'h1010;
        bus.instr_ready = 1'b1;
        apply_reset(8'h50);
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_valid} !== {16'h5A5A, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset_instr: instr=%h valid=%b, want 5A5A/1", bus.instr, bus.instr_valid);
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd, bus.halted, bus.mem_addr} !== 42'd0) begin
            miscompares++;
            $display("FAIL async_reset: instr=%h pc=%h valid=%b rd=%b halted=%b addr=%h, want all zero",
                     bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_rd, bus.halted, bus.mem_addr);
        end
        bus.start_pc = 8'($urandom);
        tick();
        bus.start_pc = 8'h10;
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'h10}) begin
            miscompares++;
            $display("FAIL restart_addr: rd=%b addr=%h, want 1/10", bus.mem_rd, bus.mem_addr);
        end
        tick();
        tick();
        vectors++;
        if ({bus.instr, bus.instr_pc, bus.instr_valid} !== {16'h1010, 8'h10, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_instr: instr=%h pc=%h valid=%b, want 1010/10/1", bus.instr, bus.instr_pc, bus.instr_valid);
        end
    endtask

    initial begin
        logic [15:0] w;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.start_pc = 8'h00;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 8'h00;
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111) w[15:13] = 3'b011;
            mem[a] = w;
        end
        test_reset();
        test_first_fetch_and_hold();
        test_pc_wrap();
        test_redirect_and_random_stream();
        test_back_to_back();
        test_halt();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
